// File: rtl/cfs_edge_detect_multi.sv
// cfs_edge_detect_multi
//   Multi-channel edge detector for asynchronous or noisy level inputs.
//   Each channel runs through an optional synchroniser and a glitch filter.
//   An edge-mode select then turns accepted level changes into one-cycle
//   detect pulses. Sticky pending/overflow flags are write-1-to-clear.
//   Masked pending flags are ORed into a single interrupt.
//
// Ports
//   clk       : clock, all logic on the rising edge
//   reset_n   : asynchronous, active-low reset
//   data      : [N_CH]   raw channel inputs
//   edge_sel  : [2*N_CH] per-channel mode, bits [2i+1:2i]
//               (00 off, 01 rising, 10 falling, 11 both)
//   filt_len  : [FILT_W] extra stable cycles before a level change is accepted
//   irq_en    : [N_CH]   per-channel interrupt mask
//   clr       : [N_CH]   write-1-to-clear for pending and overflow
//   detected  : [N_CH]   one-cycle pulse per accepted qualifying edge
//   pending   : [N_CH]   sticky edge-seen flag
//   overflow  : [N_CH]   sticky flag, edge seen while pending was already set
//   irq       : OR of pending & irq_en
module cfs_edge_detect_multi #(
  parameter int              N_CH        = 4,
  parameter int              SYNC_STAGES = 2,
  parameter int              FILT_W      = 4,
  parameter logic [N_CH-1:0] RST_VAL     = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_CH-1:0]     data,
  input  logic [2*N_CH-1:0]   edge_sel,
  input  logic [FILT_W-1:0]   filt_len,
  input  logic [N_CH-1:0]     irq_en,
  input  logic [N_CH-1:0]     clr,
  output logic [N_CH-1:0]     detected,
  output logic [N_CH-1:0]     pending,
  output logic [N_CH-1:0]     overflow,
  output logic                irq
);

  // Synchronised view of the inputs seen by the filter.
  logic [N_CH-1:0] s;

  // The synchroniser resets to RST_VAL so that an input already sitting at
  // its idle level does not look like an edge once reset is released.
  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign s = data;
    end else begin : g_sync
      logic [N_CH-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= RST_VAL;
          end
        end else begin
          sync_q[0] <= data;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Filter state: accepted level plus a count of how long s has disagreed.
  logic [N_CH-1:0]   flt;
  logic [FILT_W-1:0] cnt [N_CH];
  logic [N_CH-1:0]   accept;
  logic [N_CH-1:0]   det_next;

  // A change is accepted once the disagreement has already lasted filt_len
  // cycles. The >= compare means a filt_len lowered mid-count accepts on the
  // next cycle instead of stalling. The counter never passes filt_len.
  always_comb begin
    accept   = '0;
    det_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      accept[i]   = (s[i] != flt[i]) && (cnt[i] >= filt_len);
      det_next[i] = accept[i] &
                    ((s[i] & edge_sel[2*i]) | (~s[i] & edge_sel[2*i+1]));
    end
  end

  // Filter registers: restart the count whenever s agrees with the
  // accepted level, so short glitches leave no trace.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flt <= RST_VAL;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (s[i] == flt[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          flt[i] <= s[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Detect pulse and sticky flags. A detection arriving in the same cycle
  // as its clear wins on pending, and is not counted as an overflow
  // because the clear consumed the earlier event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      detected <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      detected <= det_next;
      pending  <= (pending & ~clr) | detected;
      overflow <= (overflow & ~clr) | (detected & pending & ~clr);
    end
  end

  assign irq = |(pending & irq_en);

endmodule

// File: tb/tb_cfs_edge_detect_multi.sv
// tb_cfs_edge_detect_multi
//   Bench for cfs_edge_detect_multi with N_CH=4, SYNC_STAGES=2, FILT_W=4
//   and RST_VAL=4'b0100. A behavioural model predicts the outputs from the
//   stream of sampled inputs. Directed scenarios pin individual values, and
//   a randomized phase exercises everything else.
module tb_cfs_edge_detect_multi;

  localparam int              N_CH    = 4;
  localparam int              SYNC    = 2;
  localparam int              FILT_W  = 4;
  localparam logic [N_CH-1:0] RST_VAL = 4'b0100;

  logic                clk      = 1'b0;
  logic                reset_n  = 1'b0;
  logic [N_CH-1:0]     data     = RST_VAL;
  logic [2*N_CH-1:0]   edge_sel = '0;
  logic [FILT_W-1:0]   filt_len = '0;
  logic [N_CH-1:0]     irq_en   = '0;
  logic [N_CH-1:0]     clr      = '0;
  logic [N_CH-1:0]     detected;
  logic [N_CH-1:0]     pending;
  logic [N_CH-1:0]     overflow;
  logic                irq;

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 1'b0;

  always #5 clk = ~clk;

  cfs_edge_detect_multi #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC), .FILT_W(FILT_W), .RST_VAL(RST_VAL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .data(data), .edge_sel(edge_sel),
    .filt_len(filt_len), .irq_en(irq_en), .clr(clr),
    .detected(detected), .pending(pending), .overflow(overflow), .irq(irq)
  );

  // Reference model. dq holds the last SYNC sampled data words (oldest at
  // the front), so the filter sees the input from SYNC clocks ago. m_run is
  // how many consecutive samples have disagreed with the accepted level.
  logic [N_CH-1:0] dq [$];
  logic [N_CH-1:0] m_flt, m_det, m_pend, m_ovf;
  logic [N_CH-1:0] s_v, det_v;
  int              m_run [N_CH];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_flt  = RST_VAL;
      m_det  = '0;
      m_pend = '0;
      m_ovf  = '0;
      foreach (m_run[i]) m_run[i] = 0;
      dq.delete();
      repeat (SYNC) dq.push_back(RST_VAL);
    end else begin
      if (SYNC == 0) begin
        s_v = data;
      end else begin
        s_v = dq.pop_front();
        dq.push_back(data);
      end
      det_v = '0;
      for (int i = 0; i < N_CH; i++) begin
        if (s_v[i] !== m_flt[i]) begin
          m_run[i]++;
          if (m_run[i] >= int'(filt_len) + 1) begin
            m_flt[i] = s_v[i];
            m_run[i] = 0;
            if (s_v[i] ? edge_sel[2*i] : edge_sel[2*i+1]) det_v[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_ovf  = (m_ovf & ~clr) | (m_det & m_pend & ~clr);
      m_pend = (m_pend & ~clr) | m_det;
      m_det  = det_v;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check_output("model_detected", detected, m_det);
      check_output("model_pending", pending, m_pend);
      check_output("model_overflow", overflow, m_ovf);
      check_output("model_irq", irq, |(m_pend & irq_en));
    end
  end

  // Advance n cycles, landing just after a falling edge so inputs change
  // well away from the rising edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [N_CH-1:0] d,
                                input logic [2*N_CH-1:0] sel,
                                input logic [FILT_W-1:0] fl);
    data     = d;
    edge_sel = sel;
    filt_len = fl;
  endtask

  task automatic count_pulses(input logic [N_CH-1:0] mask, input int n,
                              output int cnt);
    cnt = 0;
    repeat (n) begin
      tick(1);
      if (|(detected & mask)) cnt++;
    end
  endtask

  int pulses;

  initial begin
    // Power-up reset with ch2 already at its idle-high RST_VAL level.
    apply_stimulus(RST_VAL, 8'b11_10_11_01, 4'd0);
    tick(3);
    check_output("reset_detected", detected, 0);
    check_output("reset_pending", pending, 0);
    check_output("reset_irq", irq, 0);
    check_en = 1'b1;
    reset_n  = 1'b1;
    tick(4);
    check_output("no_false_edge_pending", pending, 0);

    // Ch0 rising, filt_len=0: pulse only after the third rising edge.
    data[0] = 1'b1;
    tick(1);
    check_output("t1_det_k0", detected[0], 0);
    tick(1);
    check_output("t1_det_k1", detected[0], 0);
    tick(1);
    check_output("t1_det_k2", detected[0], 1);
    tick(1);
    check_output("t1_det_k3", detected[0], 0);
    check_output("t1_pending", pending[0], 1);
    irq_en = 4'b0001;
    #1;
    check_output("t1_irq_en", irq, 1);
    irq_en = 4'b0000;
    #1;
    check_output("t1_irq_masked", irq, 0);

    // Ch1 both edges, filt_len=3: a 3-cycle pulse is filtered out.
    filt_len = 4'd3;
    data[1]  = 1'b1;
    tick(3);
    data[1] = 1'b0;
    count_pulses(4'b0010, 12, pulses);
    check_output("t2_short_pulses", pulses, 0);
    check_output("t2_short_pending", pending[1], 0);
    data[1] = 1'b1;
    tick(5);
    check_output("t2_before_k5", detected[1], 0);
    data[1] = 1'b0;
    tick(1);
    check_output("t2_pulse_k5", detected[1], 1);
    count_pulses(4'b0010, 12, pulses);
    check_output("t2_fall_pulses", pulses, 1);

    // Clear everything, then ch2 falling with overflow.
    filt_len = 4'd0;
    clr = 4'b1111;
    tick(1);
    clr = 4'b0000;
    check_output("clr_all_pending", pending, 0);
    check_output("clr_all_overflow", overflow, 0);
    data[2] = 1'b0;
    count_pulses(4'b0100, 5, pulses);
    check_output("t3_fall1", pulses, 1);
    check_output("t3_pending", pending[2], 1);
    data[2] = 1'b1;
    count_pulses(4'b0100, 5, pulses);
    check_output("t3_rise_ignored", pulses, 0);
    check_output("t3_no_ovf_yet", overflow[2], 0);
    data[2] = 1'b0;
    count_pulses(4'b0100, 5, pulses);
    check_output("t3_fall2", pulses, 1);
    check_output("t3_overflow", overflow[2], 1);
    clr = 4'b0100;
    tick(1);
    clr = 4'b0000;
    check_output("t3_clr_pending", pending[2], 0);
    check_output("t3_clr_overflow", overflow[2], 0);

    // Ch3: detection coinciding with its clear keeps pending, no overflow.
    data[3] = 1'b1;
    tick(5);
    check_output("t4_pending_set", pending[3], 1);
    data[3] = 1'b0;
    tick(3);
    check_output("t4_det_now", detected[3], 1);
    clr = 4'b1000;
    tick(1);
    clr = 4'b0000;
    check_output("t4_pend_kept", pending[3], 1);
    check_output("t4_no_ovf", overflow[3], 0);

    // All channels toggle together with modes off/rise/fall/both.
    data = 4'b0000;
    tick(6);
    edge_sel = 8'b11_10_01_00;
    data = 4'b1111;
    tick(3);
    check_output("t5_all_rise", detected, 4'b1010);
    tick(3);
    data = 4'b0000;
    tick(3);
    check_output("t5_all_fall", detected, 4'b1100);
    tick(3);

    // Reset in the middle of a ch0 filter count.
    edge_sel = 8'b11_10_11_01;
    filt_len = 4'd5;
    irq_en   = 4'b1111;
    data[0]  = 1'b1;
    tick(4);
    check_output("t6_pending_before", pending != 0, 1);
    reset_n = 1'b0;
    #1;
    check_output("t6_rst_detected", detected, 0);
    check_output("t6_rst_pending", pending, 0);
    check_output("t6_rst_overflow", overflow, 0);
    check_output("t6_rst_irq", irq, 0);
    data = RST_VAL;
    tick(2);
    reset_n = 1'b1;
    count_pulses(4'b1111, 20, pulses);
    check_output("t6_no_pulse_after", pulses, 0);
    check_output("t6_pending_after", pending, 0);

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(0, 5) == 0) data[i] = ~data[i];
        clr[i] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 39) == 0) filt_len = FILT_W'($urandom_range(0, 4));
      if ($urandom_range(0, 49) == 0) edge_sel = 8'($urandom);
      if ($urandom_range(0, 19) == 0) irq_en = 4'($urandom);
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) reset_n = 1'b0;
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cfs_edge_detect_multi.md
Name: cfs_edge_detect_multi

Overview:
- Multi-channel, parametrised edge detector for asynchronous or noisy level inputs (status lines, external strobes) feeding the core's interrupt/status logic.
- Each channel has:
  - an optional synchroniser;
  - a programmable glitch filter;
  - a per-channel edge-mode select (rise/fall/both/off);
  - a one-cycle detect pulse;
  - sticky pending and overflow flags with write-1-to-clear.
- Masked pending flags are ORed into a single irq.

Parameters:
- N_CH, 4, number of independent channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (0..4; 0 = bypass, input used directly).
- FILT_W, 4, width of the filter counter and of filt_len.
- RST_VAL, {N_CH{1'b0}}, per-channel reset level of the synchroniser and filtered level (prevents a false edge after reset).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- data  input  N_CH  raw channel inputs.
- edge_sel  input  2*N_CH  per channel, bits [2i+1:2i] select the edge mode:
  - 00 = off
  - 01 = rising
  - 10 = falling
  - 11 = both
- filt_len  input  FILT_W  extra stable cycles required before a level change is accepted, shared by all channels.
- irq_en  input  N_CH  per-channel interrupt mask.
- clr  input  N_CH  write-1-to-clear, single cycle, for pending and overflow.
- detected  output  N_CH  one-cycle pulse per accepted qualifying edge.
- pending  output  N_CH  sticky edge-seen flag.
- overflow  output  N_CH  sticky flag: edge detected while pending was already set.
- irq  output  1  |(pending & irq_en), combinational from registers.

Behaviour:

Reset (reset_n=0, asynchronous):
- Synchroniser flops and filtered level flt[i] <= RST_VAL[i]; filter counters <= 0.
- detected, pending, overflow <= 0; irq = 0.
- The first cycle after reset release produces no edge unless data differs from RST_VAL, and then only after full latency.

Synchroniser:
- SYNC_STAGES-deep shift register per channel; s[i] is its last stage, or data[i] when SYNC_STAGES=0.

Filter, per channel, each rising clk:
- If s[i]==flt[i]: cnt[i] <= 0.
- Else if cnt[i] >= filt_len: flt[i] <= s[i], cnt[i] <= 0 (level accepted).
- Else: cnt[i] <= cnt[i]+1.
- A change is accepted only if s[i] holds its new value for filt_len+1 consecutive cycles; shorter pulses are discarded with no detection.
- Using >= means lowering filt_len mid-count accepts on the next cycle, never stalls.
- The counter saturates naturally (bounded by filt_len); no wrap-around.

Detection:
- Accept event = flt changes this cycle.
- rise = accept & s[i]==1; fall = accept & s[i]==0.
- detected[i] <= (rise & edge_sel[2i]) | (fall & edge_sel[2i+1]); registered, high exactly one cycle, concurrent with the new flt value.
- Latency from a data change (set up before edge k) to detected high: SYNC_STAGES+filt_len+1 rising edges.
- Mode 00: flt still tracks the input, detected stays 0.
- Changing edge_sel never creates an event by itself; the new mode applies from the next accept.

Pending / overflow, per channel each cycle:
- pending <= (pending & ~clr) | detected.
- overflow <= (overflow & ~clr) | (detected & pending & ~clr).
- Simultaneous detected and clr: pending ends 1, overflow not set (set wins, the cleared event is considered consumed).
- clr with no pending has no effect.

Channels are fully independent; simultaneous events on multiple channels are all captured the same cycle.

Reset asserted mid-filter or mid-pulse:
- Immediately clears all state.
- A pending edge is lost; no pulse is emitted on release unless the input then differs from RST_VAL.

Test Plan:
- Defaults, filt_len=0, ch0 rising: data[0] 0->1 at edge k -> detected[0] high only in cycle after edge k+2, pending[0]=1, irq=1 with irq_en[0]=1; irq=0 with irq_en[0]=0.
- filt_len=3, ch1 both: data[1] high for 3 cycles then low -> no detected, pending[1]=0. Then high for 5 cycles -> one pulse at edge k+5; falling transition -> second pulse.
- ch2 falling, RST_VAL[2]=1, data[2]=1 through reset release -> no pulse. Then 1->0 -> one pulse. Second fall before clr -> overflow[2]=1. clr[2] -> both flags 0.
- detected[3] and clr[3] in same cycle with pending[3]=1 -> pending[3]=1, overflow[3]=0.
- All channels toggle in the same cycle with mixed edge_sel (00/01/10/11) -> detected matches each mode exactly; mode-00 channel stays 0.
- reset_n pulsed low while ch0 filter counter is mid-count (filt_len=5) -> all outputs 0 immediately. After release, input stable at RST_VAL -> no detection.
